// File: rtl/alu_iter.sv
// alu_iter: sequential ALU behind a start/done handshake; base ops complete in one cycle.
// Define ALU_MULDIV_EN to add iterative MUL/MULHU/DIVU/REMU taking WIDTH cycles.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLTU = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             accept_s;
  logic             iter_go_s;
  logic             div_zero_s;
  logic             last_step_s;
  logic [WIDTH-1:0] fin_res_s;
  logic [WIDTH-1:0] quick_res_s;
  logic             quick_err_s;

  function automatic logic [WIDTH-1:0] base_op(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  base_op = a + b;
      OP_SUB:  base_op = a - b;
      OP_SLTU: base_op = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRL:  base_op = a >> sh;
      OP_SLL:  base_op = a << sh;
      OP_OR:   base_op = a | b;
      OP_AND:  base_op = a & b;
      OP_XOR:  base_op = a ^ b;
      OP_SLT:  base_op = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SRA:  base_op = WIDTH'($signed(a) >>> sh);
      default: base_op = {WIDTH{1'b0}};
    endcase
  endfunction

  // Without the iterative unit, the multiply/divide opcodes fall into the reserved space
  function automatic logic is_reserved(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    is_reserved = (op == 4'b1110) || (op == 4'b1111);
`else
    is_reserved = (op >= 4'b1010);
`endif
  endfunction

  assign accept_s = (state_q == S_IDLE) && start;

`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_iter_s;
  logic             is_div_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_hi_s, mul_lo_s;
  logic [WIDTH:0]   div_sh_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_sub_s, div_rem_s, div_quo_s;

  // Classify the incoming opcode for dispatch at acceptance
  always_comb begin
    is_iter_s  = (Operation >= OP_MUL) && (Operation <= OP_REMU);
    is_div_s   = (Operation == OP_DIVU) || (Operation == OP_REMU);
    div_zero_s = is_div_s && (DataB == {WIDTH{1'b0}});
    iter_go_s  = is_iter_s && !div_zero_s;
  end

  // One iteration step: hi/lo hold partial product + multiplier, or remainder + quotient
  always_comb begin
    mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_hi_s  = mul_sum_s[WIDTH:1];
    mul_lo_s  = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    div_sh_s  = {hi_q, lo_q[WIDTH-1]};
    div_ge_s  = (div_sh_s >= {1'b0, b_q});
    // When div_ge_s the true difference is below 2^WIDTH, so the truncated subtract is exact
    div_sub_s = div_sh_s[WIDTH-1:0] - b_q;
    div_rem_s = div_ge_s ? div_sub_s : div_sh_s[WIDTH-1:0];
    div_quo_s = {lo_q[WIDTH-2:0], div_ge_s};
    last_step_s = (cnt_q == SHW'(WIDTH-1));
    case (op_q)
      OP_MUL:   fin_res_s = mul_lo_s;
      OP_MULHU: fin_res_s = mul_hi_s;
      OP_DIVU:  fin_res_s = div_quo_s;
      OP_REMU:  fin_res_s = div_rem_s;
      default:  fin_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Iteration register next-state: load at acceptance, step while in CALC
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept_s) begin
      cnt_d = {SHW{1'b0}};
      op_d  = Operation;
      a_d   = DataA;
      b_d   = DataB;
      hi_d  = {WIDTH{1'b0}};
      lo_d  = is_div_s ? DataA : DataB;
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + SHW'(1);
      if (op_q[2]) begin
        hi_d = div_rem_s;
        lo_d = div_quo_s;
      end else begin
        hi_d = mul_hi_s;
        lo_d = mul_lo_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Iteration registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cnt_q <= {SHW{1'b0}};
      op_q  <= 4'b0000;
      a_q   <= {WIDTH{1'b0}};
      b_q   <= {WIDTH{1'b0}};
      hi_q  <= {WIDTH{1'b0}};
      lo_q  <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end
`else
  // No iterative unit: every accepted opcode finishes in one cycle
  always_comb begin
    iter_go_s   = 1'b0;
    div_zero_s  = 1'b0;
    last_step_s = 1'b0;
    fin_res_s   = {WIDTH{1'b0}};
  end
`endif

  // Single-cycle result, including the divide-by-zero conventions
  always_comb begin
    quick_res_s = base_op(Operation, DataA, DataB);
    quick_err_s = is_reserved(Operation);
    if (div_zero_s) begin
      quick_err_s = 1'b1;
      quick_res_s = Operation[0] ? DataA : {WIDTH{1'b1}};
    end else begin
      quick_err_s = quick_err_s;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = iter_go_s ? S_CALC : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_step_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Result/flags load only on the edge that enters DONE
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    if (accept_s && !iter_go_s) begin
      result_d = quick_res_s;
      zero_d   = (quick_res_s == {WIDTH{1'b0}});
      err_d    = quick_err_s;
    end else if ((state_q == S_CALC) && last_step_s) begin
      result_d = fin_res_s;
      zero_d   = (fin_res_s == {WIDTH{1'b0}});
      err_d    = 1'b0;
    end else begin
      result_d = result_q;
    end
  end

  // Result/flag registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, multi-cycle sequences,
// and random operations against an arithmetic reference model.
module tb_alu_iter;
  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int ITER_LAT = MD ? (W + 1) : 1;
  localparam bit ITER_ERR = MD ? 1'b0 : 1'b1;

  logic         CLK = 1'b0;
  logic         RST_n;
  logic         start;
  logic [3:0]   Operation;
  logic [W-1:0] DataA, DataB;
  logic         busy, done, Zero, err;
  logic [W-1:0] Result;

  int           n_checks = 0;
  int           n_err    = 0;
  logic [W-1:0] held;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         er;
    int           lat;
  } vec_t;
  vec_t vecs[$];

  alu_iter #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .Operation(Operation),
    .DataA(DataA), .DataB(DataB), .busy(busy), .done(done),
    .Result(Result), .Zero(Zero), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic e, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = r; v.er = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Reference model from the opcode definitions using wide arithmetic
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic e, output int lat);
    logic [2*W-1:0] p;
    logic [W-1:0]   fill;
    int             sh;
    sh   = int'(b % W);
    p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    fill = a[W-1] ? ~({W{1'b1}} >> sh) : {W{1'b0}};
    r = {W{1'b0}}; e = 1'b0; lat = 1;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = (a < b) ? 32'd1 : 32'd0;
      4'd3:  r = a >> sh;
      4'd4:  r = a << sh;
      4'd5:  r = a | b;
      4'd6:  r = a & b;
      4'd7:  r = a ^ b;
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a >> sh) | fill;
      4'd10: if (MD) begin r = p[W-1:0];   lat = W + 1; end else e = 1'b1;
      4'd11: if (MD) begin r = p[2*W-1:W]; lat = W + 1; end else e = 1'b1;
      4'd12: if (!MD) e = 1'b1;
             else if (b == 0) begin r = {W{1'b1}}; e = 1'b1; end
             else begin r = a / b; lat = W + 1; end
      4'd13: if (!MD) e = 1'b1;
             else if (b == 0) begin r = a; e = 1'b1; end
             else begin r = a % b; lat = W + 1; end
      default: e = 1'b1;
    endcase
  endtask

  // One handshake; inputs are scrambled after acceptance, optional start pulses while busy
  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_e,
                        input int exp_lat, input bit pulse);
    int lat;
    bit busy_ok, hold_ok;
    @(negedge CLK);
    start = 1'b1; Operation = op; DataA = a; DataB = b;
    @(posedge CLK); #1;
    Operation = 4'($urandom); DataA = $urandom; DataB = $urandom;
    lat = 1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 3 * W) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (Result !== held) hold_ok = 1'b0;
      start = pulse ? 1'($urandom) : 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    start = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    held = exp_r;
    check({nm, "_result"}, 64'(Result), 64'(exp_r));
    check({nm, "_zero"}, 64'(Zero), 64'(exp_r == 0));
    check({nm, "_err"}, 64'(err), 64'(exp_e));
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_busy"}, 64'(busy_ok), 64'd1);
    check({nm, "_hold"}, 64'(hold_ok), 64'd1);
    @(posedge CLK); #1;
    check({nm, "_done_pulse"}, 64'(done), 64'd0);
    check({nm, "_idle"}, 64'(busy), 64'd0);
    check({nm, "_held"}, 64'(Result), 64'(held));
  endtask

  initial begin
    logic [W-1:0] r, a, b;
    logic [3:0]   op;
    logic         e;
    int           lat;
    bit           saw;

    RST_n = 1'b0; start = 1'b0; Operation = 4'd0; DataA = '0; DataB = '0; held = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_result", 64'(Result), 64'd0);
    check("rst_zero", 64'(Zero), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    add_vec(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    add_vec(4'b1000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    add_vec(4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    add_vec(4'b1001, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1);
    add_vec(4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
    add_vec(4'b0011, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 1'b0, 1);
    add_vec(4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1);
    add_vec(4'b0101, 32'h00F0_0F00, 32'h0F00_00F0, 32'h0FF0_0FF0, 1'b0, 1);
    add_vec(4'b0110, 32'h00F0_0FF0, 32'h0FF0_00F0, 32'h00F0_00F0, 1'b0, 1);
    add_vec(4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
    add_vec(4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, ITER_ERR, ITER_LAT);
    add_vec(4'b1011, 32'h0001_0000, 32'h0001_0000, MD ? 32'h0000_0001 : 32'h0, ITER_ERR, ITER_LAT);
    add_vec(4'b1100, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, ITER_ERR, ITER_LAT);
    add_vec(4'b1101, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, ITER_ERR, ITER_LAT);
    add_vec(4'b1100, 32'd5, 32'd0, MD ? 32'hFFFF_FFFF : 32'h0, 1'b1, 1);
    add_vec(4'b1101, 32'd5, 32'd0, MD ? 32'd5 : 32'd0, 1'b1, 1);
    add_vec(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1);
    add_vec(4'b1110, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
    add_vec(4'b0000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].er, vecs[i].lat, (i % 2) == 1);
    end

    // Back-to-back with start held high; second operation uses the new operands
    @(negedge CLK);
    start = 1'b1; Operation = 4'b0000; DataA = 32'd2; DataB = 32'd3;
    @(posedge CLK); #1;
    DataA = 32'd10; DataB = 32'd20;
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_res1", 64'(Result), 64'd5);
    @(posedge CLK); #1;
    check("b2b_gap_done", 64'(done), 64'd0);
    check("b2b_gap_busy", 64'(busy), 64'd0);
    @(posedge CLK); #1;
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_res2", 64'(Result), 64'd30);
    start = 1'b0;
    @(posedge CLK); #1;
    held = 32'd30;

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case (i % 4)
        0:       b = 32'($urandom_range(0, 40));
        1:       b = '0;
        default: b = $urandom;
      endcase
      if (i % 8 == 3) a = 32'($urandom_range(0, 1000));
      ref_model(op, a, b, r, e, lat);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, r, e, lat, i[0]);
    end

    // Reset during a multiply aborts it without a done pulse
    @(negedge CLK);
    start = 1'b1; Operation = 4'b1010; DataA = 32'h0001_0000; DataB = 32'h0001_0000;
    @(posedge CLK); #1;
    start = 1'b0;
    saw = 1'b0;
    repeat (9) begin
      @(posedge CLK); #1;
      if (done) saw = 1'b1;
    end
`ifdef ALU_MULDIV_EN
    check("mid_mul_no_done", 64'(saw), 64'd0);
    check("mid_mul_busy", 64'(busy), 64'd1);
`endif
    @(negedge CLK);
    RST_n = 1'b0;
    @(posedge CLK); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(Result), 64'd0);
    check("abort_zero", 64'(Zero), 64'd1);
    check("abort_err", 64'(err), 64'd0);
    held = '0;
    @(negedge CLK);
    RST_n = 1'b1;
    saw = 1'b0;
    repeat (W + 4) begin
      @(posedge CLK); #1;
      if (done) saw = 1'b1;
    end
    check("abort_no_late_done", 64'(saw), 64'd0);
    run_op("post_rst_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
